rk_tape_player: RTL and testbench

- Cassette-signal transmitter that drives the PPA1 port C tape-input bit (currently tied low at the top level).
- Serialises a byte stream as Radio-86RK/Apogee biphase tape audio so the monitor ROM's tape-read routine can load a file.
- The stream comes from the file-download path through a ready/valid byte FIFO interface.
- Sits beside data_io and rk_kbd in the top level and runs on clk_sys.

---
 rtl/rk_tape_pkg.sv | 20 ++
 rtl/rk_tape_bitclk.sv | 40 ++++
 rtl/rk_tape_player.sv | 230 +++++++++++++++++++++++
 tb/tb_rk_tape_player.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rk_tape_pkg.sv
// Shared types, default constants and line-coding helper for the RK tape player.
package rk_tape_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEADER = 3'd1,
        SYNC   = 3'd2,
        DATA   = 3'd3,
        TRAIL  = 3'd4
    } state_t;

    localparam logic [7:0] RK_SYNC_BYTE    = 8'hE6;
    localparam int         RK_LEADER_BYTES = 256;

    // Biphase line level: the first half carries the inverted bit, the second half the bit itself.
    function automatic logic biphase_level(input logic data_bit, input logic half_sel);
        return half_sel ? data_bit : ~data_bit;
    endfunction

endpackage

// File: rtl/rk_tape_bitclk.sv
// Half-period timer and half index (0..15 within a byte) for the tape serialiser.
module rk_tape_bitclk #(
    parameter int HALF_BIT = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       half_tick,
    output logic       byte_tick,
    output logic [3:0] half
);

    localparam int             TW     = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [TW-1:0]  RELOAD = TW'(HALF_BIT - 1);

    logic [TW-1:0] r_timer;
    logic [3:0]    r_half;

    assign half_tick = run & (r_timer == {TW{1'b0}});
    assign byte_tick = half_tick & (r_half == 4'd15);
    assign half      = r_half;

    // Count down one half-period while running; stay preloaded while stopped so a new start begins on a full half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= {TW{1'b0}};
            r_half  <= 4'd0;
        end else if (!run) begin
            r_timer <= RELOAD;
            r_half  <= 4'd0;
        end else if (r_timer == {TW{1'b0}}) begin
            r_timer <= RELOAD;
            r_half  <= r_half + 4'd1;
        end else begin
            r_timer <= r_timer - TW'(1);
            r_half  <= r_half;
        end
    end

endmodule

// File: rtl/rk_tape_player.sv
// Radio-86RK/Apogee cassette transmitter: leader, sync byte and payload as biphase tape audio.
module rk_tape_player
    import rk_tape_pkg::*;
#(
    parameter int         HALF_BIT     = 12500,
    parameter int         LEADER_BYTES = RK_LEADER_BYTES,
    parameter logic [7:0] SYNC_BYTE    = RK_SYNC_BYTE,
    parameter int         TRAIL_HALVES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       tape_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [8:0] LEADER_LAST = 9'(LEADER_BYTES - 1);
    localparam logic [7:0] TRAIL_LAST  = 8'(TRAIL_HALVES - 1);

    state_t     r_state,      w_state_n;
    logic [8:0] r_byte_cnt,   w_byte_cnt_n;
    logic [7:0] r_shreg,      w_shreg_n;
    logic       r_tape,       w_tape_n;
    logic       r_busy,       w_busy_n;
    logic       r_done,       w_done_n;
    logic       r_underrun,   w_underrun_n;
    logic [7:0] r_hold,       w_hold_n;
    logic       r_hold_valid, w_hold_valid_n;
    logic       r_hold_last,  w_hold_last_n;
    logic       r_last_seen,  w_last_seen_n;
    logic       r_cur_last,   w_cur_last_n;
    logic [7:0] r_trail_cnt,  w_trail_cnt_n;

    logic       w_run;
    logic       w_half_tick;
    logic       w_byte_tick;
    logic [3:0] w_half;
    logic [3:0] w_nhalf;
    logic [2:0] w_nidx;
    logic       w_next_level;
    logic       w_din_ready;
    logic       w_hs;

    assign w_run        = (r_state != IDLE);
    assign w_nhalf      = w_half + 4'd1;
    assign w_nidx       = 3'd7 - w_nhalf[3:1];
    assign w_next_level = biphase_level(r_shreg[w_nidx], w_nhalf[0]);
    assign w_din_ready  = r_busy & ~r_hold_valid & ~r_last_seen;
    assign w_hs         = din_valid & w_din_ready;

    rk_tape_bitclk #(
        .HALF_BIT (HALF_BIT)
    ) u_bitclk (
        .clk       (clk),
        .reset     (reset),
        .run       (w_run),
        .half_tick (w_half_tick),
        .byte_tick (w_byte_tick),
        .half      (w_half)
    );

    // Next-state, next-output and holding-register logic; stop overrides everything at the end.
    always_comb begin
        w_state_n      = r_state;
        w_byte_cnt_n   = r_byte_cnt;
        w_shreg_n      = r_shreg;
        w_tape_n       = r_tape;
        w_busy_n       = r_busy;
        w_done_n       = 1'b0;
        w_underrun_n   = r_underrun;
        w_hold_n       = r_hold;
        w_hold_valid_n = r_hold_valid;
        w_hold_last_n  = r_hold_last;
        w_last_seen_n  = r_last_seen;
        w_cur_last_n   = r_cur_last;
        w_trail_cnt_n  = r_trail_cnt;

        if (w_hs) begin
            w_hold_n       = din;
            w_hold_valid_n = 1'b1;
            w_hold_last_n  = din_last;
            w_last_seen_n  = din_last;
        end else begin
            w_hold_n       = r_hold;
        end

        case (r_state)
            IDLE: begin
                w_tape_n = 1'b0;
                if (start) begin
                    w_state_n      = LEADER;
                    w_busy_n       = 1'b1;
                    w_underrun_n   = 1'b0;
                    w_byte_cnt_n   = LEADER_LAST;
                    w_shreg_n      = 8'h00;
                    w_tape_n       = biphase_level(1'b0, 1'b0);
                    w_hold_valid_n = 1'b0;
                    w_hold_last_n  = 1'b0;
                    w_last_seen_n  = 1'b0;
                    w_cur_last_n   = 1'b0;
                    w_trail_cnt_n  = 8'd0;
                end else begin
                    w_busy_n = 1'b0;
                end
            end
            LEADER: begin
                if (w_byte_tick) begin
                    if (r_byte_cnt == 9'd0) begin
                        w_state_n = SYNC;
                        w_shreg_n = SYNC_BYTE;
                        w_tape_n  = biphase_level(SYNC_BYTE[7], 1'b0);
                    end else begin
                        w_byte_cnt_n = r_byte_cnt - 9'd1;
                        w_shreg_n    = 8'h00;
                        w_tape_n     = biphase_level(1'b0, 1'b0);
                    end
                end else if (w_half_tick) begin
                    w_tape_n = w_next_level;
                end else begin
                    w_tape_n = r_tape;
                end
            end
            SYNC, DATA: begin
                if (w_byte_tick) begin
                    if ((r_state == DATA) && r_cur_last) begin
                        w_state_n     = TRAIL;
                        w_tape_n      = 1'b0;
                        w_trail_cnt_n = 8'd0;
                    end else if (r_hold_valid) begin
                        w_state_n      = DATA;
                        w_shreg_n      = r_hold;
                        w_cur_last_n   = r_hold_last;
                        w_hold_valid_n = 1'b0;
                        w_tape_n       = biphase_level(r_hold[7], 1'b0);
                    end else begin
                        w_state_n     = TRAIL;
                        w_underrun_n  = 1'b1;
                        w_tape_n      = 1'b0;
                        w_trail_cnt_n = 8'd0;
                    end
                end else if (w_half_tick) begin
                    w_tape_n = w_next_level;
                end else begin
                    w_tape_n = r_tape;
                end
            end
            TRAIL: begin
                w_tape_n = 1'b0;
                if (w_half_tick) begin
                    if (r_trail_cnt == TRAIL_LAST) begin
                        w_state_n      = IDLE;
                        w_busy_n       = 1'b0;
                        w_done_n       = ~r_underrun;
                        w_hold_valid_n = 1'b0;
                        w_hold_last_n  = 1'b0;
                        w_last_seen_n  = 1'b0;
                    end else begin
                        w_trail_cnt_n = r_trail_cnt + 8'd1;
                    end
                end else begin
                    w_trail_cnt_n = r_trail_cnt;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_tape_n  = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase

        if (stop) begin
            w_state_n      = IDLE;
            w_tape_n       = 1'b0;
            w_busy_n       = 1'b0;
            w_done_n       = 1'b0;
            w_hold_valid_n = 1'b0;
            w_hold_last_n  = 1'b0;
            w_last_seen_n  = 1'b0;
        end else begin
            w_underrun_n   = w_underrun_n;
        end
    end

    // State and output registers; reset returns every register to zero/IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_byte_cnt   <= 9'd0;
            r_shreg      <= 8'h00;
            r_tape       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            r_hold_last  <= 1'b0;
            r_last_seen  <= 1'b0;
            r_cur_last   <= 1'b0;
            r_trail_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_n;
            r_byte_cnt   <= w_byte_cnt_n;
            r_shreg      <= w_shreg_n;
            r_tape       <= w_tape_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_underrun   <= w_underrun_n;
            r_hold       <= w_hold_n;
            r_hold_valid <= w_hold_valid_n;
            r_hold_last  <= w_hold_last_n;
            r_last_seen  <= w_last_seen_n;
            r_cur_last   <= w_cur_last_n;
            r_trail_cnt  <= w_trail_cnt_n;
        end
    end

    assign din_ready = w_din_ready;
    assign tape_out  = r_tape;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_rk_tape_player.sv
// Directed bench for rk_tape_player with HALF_BIT=4, LEADER_BYTES=2, TRAIL_HALVES=2.
module tb_rk_tape_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic       tape_out;
    logic       busy;
    logic       done;
    logic       underrun;

    int n_chk = 0;
    int n_bad = 0;
    int hs;

    rk_tape_player #(
        .HALF_BIT     (4),
        .LEADER_BYTES (2),
        .SYNC_BYTE    (8'hE6),
        .TRAIL_HALVES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .tape_out  (tape_out),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transfer: observation k is taken 1 time unit after edge k, edge 0 being the one that samples start.
    task automatic play(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int n, input int vdelay, input bit never,
                        input int stop_k, input int restart_k, input bit start_with_stop,
                        input int ncyc, output int hs_cnt);
        logic [7:0] seq [0:5];
        logic [7:0] cb;
        logic       e_tape, e_busy, e_done, e_ur;
        int         nd, ts, td, idx, h;
        bit         ur, stopped;
        seq[0] = 8'h00; seq[1] = 8'h00; seq[2] = 8'hE6;
        seq[3] = b0;    seq[4] = b1;    seq[5] = b2;
        nd = never ? 0 : n;
        ur = (nd == 0);
        ts = 4 * 16 * (3 + nd);
        td = ts + 8;
        idx = 0;
        hs_cnt = 0;
        din       = b0;
        din_last  = (n == 1);
        din_valid = (!never && n > 0 && vdelay == 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            stopped = (stop_k >= 0) && (k > stop_k);
            if (stopped) begin
                e_tape = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                e_ur   = ur && (stop_k >= ts);
            end else begin
                if (k < ts) begin
                    h  = k / 4;
                    cb = seq[h / 16];
                    e_tape = cb[7 - (h % 16) / 2];
                    if (h % 2 == 0) e_tape = ~e_tape;
                end else begin
                    e_tape = 1'b0;
                end
                e_busy = (k < td);
                e_done = (k == td) && !ur;
                e_ur   = ur && (k >= ts);
            end
            chk_eq($sformatf("tape k=%0d", k), tape_out, e_tape);
            chk_eq($sformatf("busy k=%0d", k), busy, e_busy);
            chk_eq($sformatf("done k=%0d", k), done, e_done);
            chk_eq($sformatf("underrun k=%0d", k), underrun, e_ur);
            if (stopped) chk_eq($sformatf("din_ready k=%0d", k), din_ready, 1'b0);
            stop  = (k == stop_k);
            start = (k == restart_k) || (start_with_stop && k == stop_k);
            if (idx < n) begin
                din      = seq[3 + idx];
                din_last = (idx == n - 1);
            end
            din_valid = !never && (idx < n) && ((k + 1) >= vdelay);
            if (din_valid && din_ready) begin
                hs_cnt++;
                idx++;
            end
            tick;
        end
        start = 1'b0; stop = 1'b0; din_valid = 1'b0; din_last = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        din = 8'h00; din_valid = 1'b0; din_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst tape", tape_out, 1'b0);
        chk_eq("rst busy", busy, 1'b0);
        chk_eq("rst done", done, 1'b0);
        chk_eq("rst din_ready", din_ready, 1'b0);
        chk_eq("rst underrun", underrun, 1'b0);
        reset = 1'b0;
        tick; tick;

        // reset in the middle of the leader
        start = 1'b1; tick; start = 1'b0;
        repeat (20) tick;
        chk_eq("busy before reset", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_eq("async rst tape", tape_out, 1'b0);
        chk_eq("async rst busy", busy, 1'b0);
        chk_eq("async rst done", done, 1'b0);
        chk_eq("async rst din_ready", din_ready, 1'b0);
        chk_eq("async rst underrun", underrun, 1'b0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk_eq($sformatf("quiet busy i=%0d", i), busy, 1'b0);
            chk_eq($sformatf("quiet tape i=%0d", i), tape_out, 1'b0);
            chk_eq($sformatf("quiet done i=%0d", i), done, 1'b0);
        end

        // single last byte A5, done at 264
        play(8'hA5, 8'h00, 8'h00, 1, 0, 1'b0, -1, -1, 1'b0, 270, hs);
        chk_eq("hs count A5", hs, 32'd1);
        repeat (3) tick;

        // two bytes, source 40 cycles late, done at 328
        play(8'h01, 8'h80, 8'h00, 2, 40, 1'b0, -1, -1, 1'b0, 335, hs);
        chk_eq("hs count 01/80", hs, 32'd2);
        repeat (3) tick;

        // source never valid: underrun, no done, busy drops at 200
        play(8'h00, 8'h00, 8'h00, 1, 0, 1'b1, -1, -1, 1'b0, 210, hs);
        chk_eq("hs count none", hs, 32'd0);
        repeat (5) tick;
        chk_eq("underrun sticky", underrun, 1'b1);
        chk_eq("idle after underrun", busy, 1'b0);

        // stop in the middle of the second payload byte; start clears underrun
        play(8'h11, 8'h22, 8'h33, 3, 0, 1'b0, 280, -1, 1'b0, 300, hs);
        chk_eq("hs count stop", hs, 32'd3);

        // replay leader; start while busy ignored, start+stop aborts
        play(8'h5A, 8'h00, 8'h00, 1, 0, 1'b0, 100, 50, 1'b1, 130, hs);
        chk_eq("hs count start+stop", hs, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
